bus_device_unit: RTL

//   Memory-mapped bus target directly downstream of the CPU MEM stage.

---
 rtl/bus_device_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bus_device_unit.sv
// Memory-mapped bus target sitting behind the CPU MEM stage: data RAM,
// reloading timer with interrupt, free-running systick, LED and digit registers.
module bus_device_unit #(
    parameter int unsigned DMEM_WORDS = 256,
    parameter int unsigned LED_W      = 8,
    parameter int unsigned DIGIT_W    = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [31:0]        MemBus_Address,
    input  logic [31:0]        MemBus_Write_Data,
    output logic [31:0]        Device_Read_Data,
    output logic [LED_W-1:0]   leds,
    output logic [DIGIT_W-1:0] digits,
    output logic               irq
);

    localparam int unsigned AW       = $clog2(DMEM_WORDS);
    localparam logic [26:0] REG_PAGE = 27'h200_0000;  // 0x4000_0000 >> 5

    localparam logic [2:0] IDX_TH      = 3'd0;
    localparam logic [2:0] IDX_TL      = 3'd1;
    localparam logic [2:0] IDX_TCON    = 3'd2;
    localparam logic [2:0] IDX_LEDS    = 3'd3;
    localparam logic [2:0] IDX_DIGITS  = 3'd4;
    localparam logic [2:0] IDX_SYSTICK = 3'd5;

    logic [31:0]        mem_q [DMEM_WORDS];
    logic [31:0]        th_q, th_d;
    logic [31:0]        tl_q, tl_d;
    logic [2:0]         tcon_q, tcon_d;
    logic [31:0]        systick_q, systick_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic [DIGIT_W-1:0] digits_q, digits_d;

    logic          ram_sel, reg_sel, ram_we;
    logic [AW-1:0] ram_idx;
    logic [2:0]    reg_idx;
    logic          wr_th, wr_tl, wr_tcon, wr_leds, wr_digits;
    logic          tl_at_max, hw_ovf, irq_set;
    logic [1:0]    unused_byte_offset;

    // Address decode; the byte offset within a word is ignored.
    assign unused_byte_offset = MemBus_Address[1:0];
    assign ram_sel   = (MemBus_Address[31:2] >> AW) == 30'd0;
    assign ram_idx   = MemBus_Address[AW+1:2];
    assign reg_sel   = MemBus_Address[31:5] == REG_PAGE;
    assign reg_idx   = MemBus_Address[4:2];
    assign ram_we    = MemWrite & ram_sel & reset;
    assign wr_th     = MemWrite & reg_sel & (reg_idx == IDX_TH);
    assign wr_tl     = MemWrite & reg_sel & (reg_idx == IDX_TL);
    assign wr_tcon   = MemWrite & reg_sel & (reg_idx == IDX_TCON);
    assign wr_leds   = MemWrite & reg_sel & (reg_idx == IDX_LEDS);
    assign wr_digits = MemWrite & reg_sel & (reg_idx == IDX_DIGITS);

    // Timer overflow event; a software TL write pre-empts it entirely.
    assign tl_at_max = tl_q == 32'hFFFF_FFFF;
    assign hw_ovf    = tcon_q[0] & tl_at_max & ~wr_tl;
    assign irq_set   = hw_ovf & tcon_q[1];

    // Zero-latency read mux; shows pre-write state during a write cycle.
    always_comb begin
        Device_Read_Data = 32'd0;
        if (MemRead) begin
            if (ram_sel) begin
                Device_Read_Data = mem_q[ram_idx];
            end else if (reg_sel) begin
                case (reg_idx)
                    IDX_TH:      Device_Read_Data = th_q;
                    IDX_TL:      Device_Read_Data = tl_q;
                    IDX_TCON:    Device_Read_Data = {29'd0, tcon_q};
                    IDX_LEDS:    Device_Read_Data = 32'(leds_q);
                    IDX_DIGITS:  Device_Read_Data = 32'(digits_q);
                    IDX_SYSTICK: Device_Read_Data = systick_q;
                    default:     Device_Read_Data = 32'd0;
                endcase
            end
        end
    end

    // Next-state for registers: software writes win over hardware updates,
    // except the irq status set, which is OR-ed in so no interrupt is lost.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        leds_d    = leds_q;
        digits_d  = digits_q;
        systick_d = systick_q + 32'd1;

        if (wr_th) th_d = MemBus_Write_Data;

        if (wr_tl) begin
            tl_d = MemBus_Write_Data;
        end else if (tcon_q[0]) begin
            tl_d = tl_at_max ? th_q : tl_q + 32'd1;
        end

        if (wr_tcon) begin
            tcon_d = {MemBus_Write_Data[2] | irq_set, MemBus_Write_Data[1:0]};
        end else begin
            tcon_d[2] = tcon_q[2] | irq_set;
        end

        if (wr_leds)   leds_d   = MemBus_Write_Data[LED_W-1:0];
        if (wr_digits) digits_d = MemBus_Write_Data[DIGIT_W-1:0];
    end

    // Register state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= 32'd0;
            tl_q      <= 32'd0;
            tcon_q    <= 3'd0;
            systick_q <= 32'd0;
            leds_q    <= '0;
            digits_q  <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
            leds_q    <= leds_d;
            digits_q  <= digits_d;
        end
    end

    // Data RAM; contents survive reset, but a write during reset is dropped.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_idx] <= MemBus_Write_Data;
    end

    assign leds   = leds_q;
    assign digits = digits_q;
    assign irq    = tcon_q[1] & tcon_q[2];

endmodule
